// File: rtl/reg_file16.sv
// Eight-entry register file with same-cycle write bypass and a per-register
// busy scoreboard used by decode to stall on pending write-backs.
module reg_file16 #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [3:0]        shamt_b,
    input  logic              issue,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              stall,
    output logic [NREG-1:0]   busy
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;

    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic              w_byp_a;
    logic              w_byp_b;

    // Register 0 is masked out of the decoded set/clear vectors so busy[0] stays 0.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue) w_set = NREG'(1) << iaddr;
        if (we)    w_clr = NREG'(1) << waddr;
        w_set[0] = 1'b0;
        w_clr[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (we && (waddr != '0)) begin
                r_regs[waddr] <= wdata;
            end
            // A new issue outranks the write-back retiring the older instruction.
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_byp_a = we && (waddr == raddr_a);
        w_byp_b = we && (waddr == raddr_b);

        rdata_a = '0;
        if (raddr_a != '0) rdata_a = w_byp_a ? wdata : r_regs[raddr_a];

        rdata_b = '0;
        if (raddr_b != '0) rdata_b = w_byp_b ? wdata : r_regs[raddr_b];

        shamt_b = rdata_b[3:0];
        stall   = (r_busy[raddr_a] && !w_byp_a) || (r_busy[raddr_b] && !w_byp_b);
        busy    = r_busy;
    end

endmodule

// File: tb/tb_reg_file16.sv
// Directed bench for reg_file16: expected values go into a queue as stimulus
// is applied and are popped and asserted when the outputs are sampled.
module tb_reg_file16;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [15:0] rdata_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_b;
    logic [3:0]  shamt_b;
    logic        issue;
    logic [2:0]  iaddr;
    logic        stall;
    logic [7:0]  busy;

    logic [15:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    reg_file16 #(.DATA_W(16), .NREG(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b),
        .shamt_b (shamt_b),
        .issue   (issue),
        .iaddr   (iaddr),
        .stall   (stall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp_v;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        logic [15:0] sll;
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; issue = 1'b0; iaddr = '0;
        tick();
        raddr_a = 3'd7; raddr_b = 3'd3; #1;
        push(16'h0000); check("rst_rdata_a", rdata_a);
        push(16'h0000); check("rst_busy", {8'h00, busy});
        push(16'h0000); check("rst_stall", {15'h0, stall});
        reset = 1'b0;
        tick();

        // Preload r1..r7 and leave r3 busy, then reset between edges.
        for (int i = 1; i < 8; i++) wr(3'(i), 16'hFFFF);
        issue = 1'b1; iaddr = 3'd3; tick(); issue = 1'b0; #1;
        push(16'hFFFF); check("preload_r7", rdata_a);
        push(16'h0008); check("preload_busy", {8'h00, busy});
        #2 reset = 1'b1; #1;
        push(16'h0000); check("async_rst_a", rdata_a);
        push(16'h0000); check("async_rst_b", rdata_b);
        push(16'h0000); check("async_rst_shamt", {12'h0, shamt_b});
        push(16'h0000); check("async_rst_busy", {8'h00, busy});
        push(16'h0000); check("async_rst_stall", {15'h0, stall});
        tick(); #2 reset = 1'b0;
        tick();
        push(16'h0000); check("post_rst_r7", rdata_a);

        // Write/read feeding the shifter.
        wr(3'd2, 16'd4);
        wr(3'd3, 16'd2);
        raddr_a = 3'd2; raddr_b = 3'd3; #1;
        push(16'd4); check("rd_a_r2", rdata_a);
        push(16'h0002); check("shamt_b_r3", {12'h0, shamt_b});
        sll = rdata_a << shamt_b;
        push(16'd16); check("sll_chain", sll);

        // Same-cycle bypass.
        we = 1'b1; waddr = 3'd5; wdata = 16'hA5A5; raddr_a = 3'd5; raddr_b = 3'd5; #1;
        push(16'hA5A5); check("bypass_a", rdata_a);
        push(16'hA5A5); check("bypass_b", rdata_b);
        tick(); we = 1'b0; #1;
        push(16'hA5A5); check("r5_stored", rdata_a);

        // Register 0 ignores writes and issues.
        we = 1'b1; waddr = 3'd0; wdata = 16'h1234; issue = 1'b1; iaddr = 3'd0;
        raddr_a = 3'd0; raddr_b = 3'd0; #1;
        push(16'h0000); check("r0_bypass_a", rdata_a);
        push(16'h0000); check("r0_bypass_b", rdata_b);
        tick(); we = 1'b0; issue = 1'b0; #1;
        push(16'h0000); check("r0_after_wr", rdata_a);
        push(16'h0000); check("r0_busy", {8'h00, busy});
        push(16'h0000); check("r0_stall", {15'h0, stall});

        // Hazard on r4: issue at edge N, write-back during cycle N+2.
        issue = 1'b1; iaddr = 3'd4; tick(); issue = 1'b0;
        raddr_a = 3'd4; raddr_b = 3'd0; #1;
        push(16'h0001); check("haz_stall", {15'h0, stall});
        push(16'h0010); check("haz_busy", {8'h00, busy});
        tick();
        push(16'h0001); check("haz_stall_hold", {15'h0, stall});
        we = 1'b1; waddr = 3'd4; wdata = 16'h0007; #1;
        push(16'h0000); check("haz_wb_stall", {15'h0, stall});
        push(16'h0007); check("haz_wb_data", rdata_a);
        tick(); we = 1'b0; #1;
        push(16'h0000); check("haz_busy_clr", {8'h00, busy});
        push(16'h0007); check("haz_r4", rdata_a);

        // Port B hazard with a one-cycle issue-to-writeback distance.
        issue = 1'b1; iaddr = 3'd1; tick(); issue = 1'b0;
        raddr_a = 3'd0; raddr_b = 3'd1; #1;
        push(16'h0001); check("hazb_stall", {15'h0, stall});
        push(16'h0002); check("hazb_busy", {8'h00, busy});
        wr(3'd1, 16'h0003); #1;
        push(16'h0000); check("hazb_busy_clr", {8'h00, busy});
        push(16'h0003); check("hazb_shamt", {12'h0, shamt_b});

        // Simultaneous set and clear on r6: set wins, data lands.
        issue = 1'b1; iaddr = 3'd6; we = 1'b1; waddr = 3'd6; wdata = 16'hBEEF;
        tick(); issue = 1'b0; we = 1'b0;
        raddr_a = 3'd6; raddr_b = 3'd0; #1;
        push(16'h0040); check("setclr_busy", {8'h00, busy});
        push(16'hBEEF); check("setclr_data", rdata_a);
        push(16'h0001); check("setclr_stall", {15'h0, stall});
        wr(3'd6, 16'h0101); #1;
        push(16'h0000); check("setclr_retire", {8'h00, busy});
        push(16'h0101); check("setclr_r6", rdata_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
